fifo_stream_reader: RTL and testbench



---
 rtl/fifo_stream_reader.sv | 139 +++++++++++++
 tb/tb_fifo_stream_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous fifo: pops words with one-cycle read latency into a
// 2-entry buffer and presents them as a valid/ready stream. Optional macro: STREAM_LAST_EN (m_last).
module fifo_stream_reader #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 fifo_rd,
    input  logic                 fifo_empty,
    input  logic [DATAWIDTH-1:0] fifo_data,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);

    if (BURST_LEN == 0 || BURST_LEN > (1 << CNT_WIDTH)) begin : g_burst_len_check
        $error("fifo_stream_reader: BURST_LEN must be in 1..2**CNT_WIDTH");
    end

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e                 state;
    occ_e                 state_next;
    logic [1:0]           occ;
    logic                 pend;
    logic                 push;
    logic                 pop;
    logic [2:0]           credit;
    logic [DATAWIDTH-1:0] head;
    logic [DATAWIDTH-1:0] tail;
    logic [DATAWIDTH-1:0] head_next;
    logic [DATAWIDTH-1:0] tail_next;

    assign occ    = state;
    assign push   = pend;
    assign pop    = m_valid && m_ready;
    assign m_data = head;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy next state; push and pop together leave occupancy unchanged
    always_comb begin
        state_next = state;
        case (state)
            OCC_EMPTY: if (push) state_next = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop) begin
                    state_next = OCC_TWO;
                end else if (pop && !push) begin
                    state_next = OCC_EMPTY;
                end
            end
            OCC_TWO: if (pop && !push) state_next = OCC_ONE;
            default: state_next = OCC_EMPTY;
        endcase
    end

    // Read strobe and buffer steering; credit includes the word still in flight
    always_comb begin
        credit    = 3'(occ) + 3'(pend) - 3'(pop);
        fifo_rd   = rstn && !fifo_empty && (credit < 3'd2);
        head_next = head;
        tail_next = tail;
        case (state)
            OCC_EMPTY: if (push) head_next = fifo_data;
            OCC_ONE: begin
                if (push && pop) begin
                    head_next = fifo_data;
                end else if (push) begin
                    tail_next = fifo_data;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    head_next = tail;
                    if (push) tail_next = fifo_data;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered stream valid
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend    <= 1'b0;
            head    <= '0;
            tail    <= '0;
            m_valid <= 1'b0;
        end else begin
            pend    <= fifo_rd;
            head    <= head_next;
            tail    <= tail_next;
            m_valid <= (state_next != OCC_EMPTY);
        end
    end

`ifdef STREAM_LAST_EN
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BURST_LEN - 1);

    logic [CNT_WIDTH-1:0] bcnt;
    logic [CNT_WIDTH-1:0] bcnt_next;

    // Burst word counter wraps on the popped last word
    always_comb begin
        bcnt_next = bcnt;
        if (pop) begin
            bcnt_next = m_last ? '0 : bcnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bcnt   <= '0;
            m_last <= 1'b0;
        end else begin
            bcnt   <= bcnt_next;
            m_last <= (state_next != OCC_EMPTY) && (bcnt_next == LAST_CNT);
        end
    end
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO source, in-order stream reference and
// burst-position model for m_last (built with or without STREAM_LAST_EN).
module tb_fifo_stream_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned BL = 4;
    localparam int unsigned MEM_DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rstn;
    logic          fifo_rd;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    logic [DW-1:0] mem [MEM_DEPTH];
    int            wptr = 0;
    int            rptr = 0;

    int            total = 0;
    int            bad = 0;
    int            ri = 0;
    int            npop = 0;
    logic [31:0]   last_mask = '0;

    fifo_stream_reader #(
        .DATAWIDTH(DW),
        .BURST_LEN(BL),
        .CNT_WIDTH(4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .fifo_rd   (fifo_rd),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    // Source FIFO: registered read data, reset discards contents
    assign fifo_empty = (rptr == wptr);
    always @(posedge clk) begin
        if (!rstn) begin
            rptr <= wptr;
        end else if (fifo_rd) begin
            fifo_data <= mem[rptr % MEM_DEPTH];
            rptr      <= rptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] d);
        mem[wptr % MEM_DEPTH] = d;
        wptr++;
    endtask

    // Stream reference: every popped word is the next loaded word since the last reset
    task automatic mon();
        logic exp_last;
        if (rstn) begin
            check("rd_while_empty", 32'(fifo_rd && fifo_empty), 32'd0);
`ifdef STREAM_LAST_EN
            exp_last = m_valid && ((npop % BL) == BL - 1);
`else
            exp_last = 1'b0;
`endif
            check("m_last", 32'(m_last), 32'(exp_last));
            if (m_valid && m_ready) begin
                check("pop_has_word", 32'(ri < wptr), 32'd1);
                check("stream_data", 32'(m_data), 32'(mem[ri % MEM_DEPTH]));
                if (m_last && npop < 32) last_mask[npop] = 1'b1;
                ri++;
                npop++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        ri = wptr;
        npop = 0;
        last_mask = '0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        int rd_cnt;
        int nload;
        int budget;
        logic [DW-1:0] w2 [4];
        w2[0] = 8'h11; w2[1] = 8'h22; w2[2] = 8'h33; w2[3] = 8'h44;

        // Reset values
        rstn = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        rstn = 1'b1;
        tick();

        // Latency and back-to-back stream of three words
        m_ready = 1'b1;
        load(8'h11); load(8'h22); load(8'h33);
        #1;
        check("t1_rd_same_cycle", 32'(fifo_rd), 32'd1);
        tick();
        check("t1_valid_n1", 32'(m_valid), 32'd0);
        tick();
        check("t1_valid_n2", 32'(m_valid), 32'd1);
        check("t1_data0", 32'(m_data), 32'h11);
        tick();
        check("t1_valid_n3", 32'(m_valid), 32'd1);
        check("t1_data1", 32'(m_data), 32'h22);
        tick();
        check("t1_valid_n4", 32'(m_valid), 32'd1);
        check("t1_data2", 32'(m_data), 32'h33);
        tick();
        check("t1_valid_end", 32'(m_valid), 32'd0);

        // Backpressure: two reads fill the buffer, head held, then gapless drain
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(w2[i]);
        #1;
        rd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (fifo_rd) rd_cnt++;
            if (i >= 2) begin
                check("t2_hold_valid", 32'(m_valid), 32'd1);
                check("t2_hold_data", 32'(m_data), 32'h11);
            end
            tick();
        end
        check("t2_rd_pulses", 32'(rd_cnt), 32'd2);
        m_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_valid", 32'(m_valid), 32'd1);
            check("t2_drain_data", 32'(m_data), 32'(w2[i]));
            tick();
        end
        check("t2_valid_end", 32'(m_valid), 32'd0);

        // Random backpressure and bursty loading of words 0..199
        nload = 0;
        budget = 0;
        while (!(nload == 200 && ri == wptr) && budget < 3000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (nload < 200 && $urandom_range(0, 1) == 1) begin
                load(8'(nload));
                nload++;
            end
            tick();
            budget++;
        end
        check("t3_all_loaded", 32'(nload), 32'd200);
        check("t3_drained", 32'(ri == wptr), 32'd1);

        // Reset with a buffered word and a read in flight
        m_ready = 1'b0;
        tick();
        load(8'h11); load(8'h22); load(8'h33);
        tick();
        tick();
        check("t4_pre_valid", 32'(m_valid), 32'd1);
        rstn = 1'b0;
        ri = wptr;
        npop = 0;
        last_mask = '0;
        #1;
        check("t4_rd_in_reset", 32'(fifo_rd), 32'd0);
        tick();
        rstn = 1'b1;
        #1;
        check("t4_valid_after", 32'(m_valid), 32'd0);
        check("t4_rd_after", 32'(fifo_rd), 32'd0);
        m_ready = 1'b1;
        load(8'hA5);
        tick();
        tick();
        check("t4_first_valid", 32'(m_valid), 32'd1);
        check("t4_first_data", 32'(m_data), 32'hA5);
        tick();

        // Burst marking over nine words
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 9; i++) load(8'(8'h50 + i));
        budget = 0;
        while (ri != wptr && budget < 100) begin
            tick();
            budget++;
        end
        check("t5_drained", 32'(ri == wptr), 32'd1);
`ifdef STREAM_LAST_EN
        check("t5_last_words", last_mask, 32'h0000_0088);
`else
        check("t5_last_words", last_mask, 32'h0000_0000);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
